// File: rtl/xillylite_slave_arbiter_pkg.sv
// Shared definitions for the Xillybus Lite slave arbiter.
//   CTRL_*     byte offsets of the registers inside the control window
//   ERR_CNT_W  width of the unmapped-access error counter
//   rd_src_e   source selected for a pending read
package xillylite_arb_pkg;

   localparam int unsigned CTRL_PENDING = 32'h0;
   localparam int unsigned CTRL_MASK    = 32'h4;
   localparam int unsigned CTRL_ERRCNT  = 32'h8;
   localparam int unsigned ERR_CNT_W    = 16;

   typedef enum logic [1:0] {
      SRC_SLAVE,
      SRC_CTRL,
      SRC_NONE
   } rd_src_e;

endpackage

// File: rtl/xillylite_slave_arbiter_irq_ctrl.sv
// Interrupt aggregation for the Lite arbiter.
//   clk_i, rst_i     user clock, synchronous active-high reset
//   s_irq_i          slave level interrupt requests
//   pend_w1c_i       write-1-to-clear strobe for PENDING (wr_bits_i)
//   mask_wr_i        write strobe for MASK (wr_bits_i gated by mask_be_i)
//   pending_o        PENDING register
//   mask_o           MASK register
//   irq_o            one-cycle interrupt pulse
module xillylite_irq_ctrl #(
   parameter int unsigned N_SLAVES = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_SLAVES-1:0] s_irq_i,
   input  logic                pend_w1c_i,
   input  logic                mask_wr_i,
   input  logic [N_SLAVES-1:0] wr_bits_i,
   input  logic [N_SLAVES-1:0] mask_be_i,
   output logic [N_SLAVES-1:0] pending_o,
   output logic [N_SLAVES-1:0] mask_o,
   output logic                irq_o
);

   logic [N_SLAVES-1:0] hist_q, pend_q, pend_d, mask_q, mask_d;
   logic                irq_q, irq_d;
   logic [N_SLAVES-1:0] rise, active_q, active_d;

   always_comb begin
      rise   = s_irq_i & ~hist_q;
      // Edge set is OR-ed after the clear so it wins over a same-cycle W1C.
      pend_d = (pend_q & ~(pend_w1c_i ? wr_bits_i : '0)) | rise;
      mask_d = mask_q;
      if (mask_wr_i) begin
         mask_d = (mask_q & ~mask_be_i) | (wr_bits_i & mask_be_i);
      end
      active_q = pend_q & mask_q;
      active_d = pend_d & mask_d;
      irq_d    = (|(active_d & ~active_q)) |
                 ((pend_w1c_i | mask_wr_i) & (|active_d));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_q <= '0;
         pend_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         hist_q <= s_irq_i;
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign pending_o = pend_q;
   assign mask_o    = mask_q;
   assign irq_o     = irq_q;

endmodule

// File: rtl/xillylite_slave_arbiter.sv
// Shares the Xillybus Lite user register port among N_SLAVES register blocks.
//   user_*      Lite user port (clock, reset, strobes, address, data, irq)
//   s_wren/s_rden  one-hot per-slave strobes decoded from the window select
//   s_addr/s_wstrb/s_wr_data  shared in-window address and write data
//   s_rd_data   concatenated slave read words, slave i at [32*i+31:32*i]
//   s_irq       slave level interrupt requests
// Window N_SLAVES holds PENDING / MASK / ERR_CNT; higher windows are unmapped.
module xillylite_slave_arbiter
   import xillylite_arb_pkg::*;
#(
   parameter int unsigned N_SLAVES = 4,
   parameter int unsigned WIN_AW   = 8,
   parameter int unsigned SEL_W    = 3
) (
   input  logic                   user_clk,
   input  logic                   user_rst,
   input  logic                   user_wren,
   input  logic [3:0]             user_wstrb,
   input  logic                   user_rden,
   input  logic [31:0]            user_addr,
   input  logic [31:0]            user_wr_data,
   output logic [31:0]            user_rd_data,
   output logic                   user_irq,
   output logic [N_SLAVES-1:0]    s_wren,
   output logic [N_SLAVES-1:0]    s_rden,
   output logic [WIN_AW-1:0]      s_addr,
   output logic [3:0]             s_wstrb,
   output logic [31:0]            s_wr_data,
   input  logic [32*N_SLAVES-1:0] s_rd_data,
   input  logic [N_SLAVES-1:0]    s_irq
);

   logic [SEL_W-1:0]  sel, rd_sel_q, rd_sel_d;
   logic [WIN_AW-1:0] off;
   logic              hit_slave, hit_ctrl, hit_none;
   logic              unused_addr_bits;
   rd_src_e           src, rd_src_q, rd_src_d;
   logic              rd_pend_q, rd_pend_d;
   logic [31:0]       rd_data_q, rd_data_d, ctrl_rd, slave_word;
   logic              pend_w1c, mask_wr, err_clr;
   logic [N_SLAVES-1:0] mask_be, pending, mask;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_CNT_W:0]   err_sum;
   logic [1:0]           err_inc;

   assign sel       = user_addr[WIN_AW+SEL_W-1:WIN_AW];
   assign off       = user_addr[WIN_AW-1:0];
   assign hit_slave = sel <  SEL_W'(N_SLAVES);
   assign hit_ctrl  = sel == SEL_W'(N_SLAVES);
   assign hit_none  = sel >  SEL_W'(N_SLAVES);
   assign unused_addr_bits = ^user_addr[31:WIN_AW+SEL_W];

   assign s_addr    = off;
   assign s_wstrb   = user_wstrb;
   assign s_wr_data = user_wr_data;

   always_comb begin
      s_wren = '0;
      s_rden = '0;
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
         if (sel == SEL_W'(i)) begin
            s_wren[i] = user_wren;
            s_rden[i] = user_rden;
         end
      end
   end

   // Control-window write decode
   assign pend_w1c = user_wren & hit_ctrl & (off == WIN_AW'(CTRL_PENDING));
   assign mask_wr  = user_wren & hit_ctrl & (off == WIN_AW'(CTRL_MASK));
   assign err_clr  = user_wren & hit_ctrl & (off == WIN_AW'(CTRL_ERRCNT));

   always_comb begin
      mask_be = '0;
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
         mask_be[i] = user_wstrb[2'(i >> 3)];
      end
   end

   xillylite_irq_ctrl #(
      .N_SLAVES (N_SLAVES)
   ) u_irq (
      .clk_i      (user_clk),
      .rst_i      (user_rst),
      .s_irq_i    (s_irq),
      .pend_w1c_i (pend_w1c),
      .mask_wr_i  (mask_wr),
      .wr_bits_i  (user_wr_data[N_SLAVES-1:0]),
      .mask_be_i  (mask_be),
      .pending_o  (pending),
      .mask_o     (mask),
      .irq_o      (user_irq)
   );

   // Error counter: one count per unmapped strobe, saturating
   always_comb begin
      err_inc   = {1'b0, user_wren & hit_none} + {1'b0, user_rden & hit_none};
      err_sum   = {1'b0, err_cnt_q} + {{(ERR_CNT_W-1){1'b0}}, err_inc};
      err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
      if (err_clr) begin
         err_cnt_d = '0;
      end
   end

   always_comb begin
      ctrl_rd = '0;
      if (off == WIN_AW'(CTRL_PENDING)) begin
         ctrl_rd[N_SLAVES-1:0] = pending;
      end else if (off == WIN_AW'(CTRL_MASK)) begin
         ctrl_rd[N_SLAVES-1:0] = mask;
      end else if (off == WIN_AW'(CTRL_ERRCNT)) begin
         ctrl_rd[ERR_CNT_W-1:0] = err_cnt_q;
      end
   end

   always_comb begin
      src = SRC_NONE;
      if (hit_slave) begin
         src = SRC_SLAVE;
      end else if (hit_ctrl) begin
         src = SRC_CTRL;
      end
   end

   always_comb begin
      slave_word = '0;
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
         if (rd_sel_q == SEL_W'(i)) begin
            slave_word = s_rd_data[32*i +: 32];
         end
      end
   end

   // Slave data only exists in the cycle after the strobe, so it is passed
   // through combinationally then and latched into rd_data_q to be held.
   // Control and unmapped results are captured at strobe time instead.
   always_comb begin
      rd_pend_d = user_rden;
      rd_src_d  = rd_src_q;
      rd_sel_d  = rd_sel_q;
      rd_data_d = rd_data_q;
      if (rd_pend_q && rd_src_q == SRC_SLAVE) begin
         rd_data_d = slave_word;
      end
      if (user_rden) begin
         rd_src_d  = src;
         rd_sel_d  = sel;
         rd_data_d = (src == SRC_CTRL) ? ctrl_rd : '0;
      end
   end

   assign user_rd_data = (rd_pend_q && rd_src_q == SRC_SLAVE) ? slave_word : rd_data_q;

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         rd_pend_q <= 1'b0;
         rd_src_q  <= SRC_NONE;
         rd_sel_q  <= '0;
         rd_data_q <= '0;
         err_cnt_q <= '0;
      end else begin
         rd_pend_q <= rd_pend_d;
         rd_src_q  <= rd_src_d;
         rd_sel_q  <= rd_sel_d;
         rd_data_q <= rd_data_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_xillylite_slave_arbiter.sv
// Self-checking bench for xillylite_slave_arbiter (N_SLAVES=4, WIN_AW=8, SEL_W=3).
module tb_xillylite_slave_arbiter;

   logic         user_clk = 1'b0;
   logic         user_rst = 1'b1;
   logic         user_wren = 1'b0;
   logic [3:0]   user_wstrb = '0;
   logic         user_rden = 1'b0;
   logic [31:0]  user_addr = '0;
   logic [31:0]  user_wr_data = '0;
   logic [31:0]  user_rd_data;
   logic         user_irq;
   logic [3:0]   s_wren, s_rden;
   logic [7:0]   s_addr;
   logic [3:0]   s_wstrb;
   logic [31:0]  s_wr_data;
   logic [127:0] s_rd_data = '0;
   logic [3:0]   s_irq = '0;

   int unsigned total = 0;
   int unsigned bad = 0;
   logic [31:0] sb[$];
   logic [31:0] slave_val[4];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [3:0]  e_wren;
      logic [3:0]  e_rden;
      logic [7:0]  e_addr;
      logic [31:0] e_rd;
   } vec_t;
   vec_t tbl[7];

   xillylite_slave_arbiter #(
      .N_SLAVES (4),
      .WIN_AW   (8),
      .SEL_W    (3)
   ) dut (
      .user_clk     (user_clk),
      .user_rst     (user_rst),
      .user_wren    (user_wren),
      .user_wstrb   (user_wstrb),
      .user_rden    (user_rden),
      .user_addr    (user_addr),
      .user_wr_data (user_wr_data),
      .user_rd_data (user_rd_data),
      .user_irq     (user_irq),
      .s_wren       (s_wren),
      .s_rden       (s_rden),
      .s_addr       (s_addr),
      .s_wstrb      (s_wstrb),
      .s_wr_data    (s_wr_data),
      .s_rd_data    (s_rd_data),
      .s_irq        (s_irq)
   );

   always #5 user_clk = ~user_clk;

   // Slave model: answers one cycle after its strobe, otherwise drives noise
   always @(posedge user_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (s_rden[i]) s_rd_data[32*i +: 32] <= slave_val[i];
         else           s_rd_data[32*i +: 32] <= $urandom;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One Lite access; the expected read word goes through the scoreboard
   task automatic acc(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [31:0] exp);
      logic [31:0] e;
      user_wren = wr; user_rden = rd; user_addr = addr;
      user_wr_data = wd; user_wstrb = st;
      if (rd) sb.push_back(exp);
      @(posedge user_clk); #1;
      user_wren = 1'b0; user_rden = 1'b0;
      if (rd) begin
         e = sb.pop_front();
         chk("rd_data", user_rd_data, e);
      end
   endtask

   initial begin
      logic [31:0] e;
      slave_val[0] = 32'h11110000;
      slave_val[1] = 32'h22221111;
      slave_val[2] = 32'h33332222;
      slave_val[3] = 32'h12345678;

      tbl[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'hDEADBEEF, 4'hF, 4'b0010, 4'b0000, 8'h04, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h0000_0308, 32'h0,       4'h0, 4'b0000, 4'b1000, 8'h08, 32'h12345678};
      tbl[2] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h0,       4'h0, 4'b0000, 4'b0001, 8'hFC, 32'h11110000};
      tbl[3] = '{1'b1, 1'b1, 32'hABCD_F2A0, 32'hCAFEF00D, 4'h5, 4'b0100, 4'b0100, 8'hA0, 32'h33332222};
      tbl[4] = '{1'b0, 1'b1, 32'h0000_040C, 32'h0,       4'h0, 4'b0000, 4'b0000, 8'h0C, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 32'hFFFF_F3FF, 32'h1,       4'h8, 4'b1000, 4'b0000, 8'hFF, 32'h0};
      tbl[6] = '{1'b0, 1'b1, 32'h1000_0200, 32'h0,       4'h0, 4'b0000, 4'b0100, 8'h00, 32'h33332222};

      // Reset state
      repeat (2) @(posedge user_clk);
      #1 user_rst = 1'b0;
      chk("reset_rd_data", user_rd_data, 32'h0);
      chk("reset_irq", {31'h0, user_irq}, 32'h0);

      // Decode and slave read path
      for (int i = 0; i < 7; i++) begin
         user_wren = tbl[i].wr; user_rden = tbl[i].rd; user_addr = tbl[i].addr;
         user_wr_data = tbl[i].wd; user_wstrb = tbl[i].st;
         #1;
         chk("s_wren",    {28'h0, s_wren}, {28'h0, tbl[i].e_wren});
         chk("s_rden",    {28'h0, s_rden}, {28'h0, tbl[i].e_rden});
         chk("s_addr",    {24'h0, s_addr}, {24'h0, tbl[i].e_addr});
         chk("s_wr_data", s_wr_data, tbl[i].wd);
         chk("s_wstrb",   {28'h0, s_wstrb}, {28'h0, tbl[i].st});
         if (tbl[i].rd) sb.push_back(tbl[i].e_rd);
         @(posedge user_clk); #1;
         user_wren = 1'b0; user_rden = 1'b0;
         if (tbl[i].rd) begin
            e = sb.pop_front();
            chk("tbl_rd_data", user_rd_data, e);
         end
      end

      // Read data holds while the slave bus changes
      acc(1'b0, 1'b1, 32'h308, 32'h0, 4'h0, 32'h12345678);
      repeat (2) begin
         @(posedge user_clk); #1;
         chk("rd_hold", user_rd_data, 32'h12345678);
      end

      // Unmapped accesses and ERR_CNT
      acc(1'b0, 1'b1, 32'h500, 32'h0, 4'h0, 32'h0);
      acc(1'b1, 1'b0, 32'h604, 32'h0, 4'hF, 32'h0);
      acc(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'h2);
      user_rden = 1'b1; user_addr = 32'h700;
      repeat (65540) @(posedge user_clk);
      #1 user_rden = 1'b0;
      acc(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'h0000FFFF);
      acc(1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 32'h0);
      acc(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'h0000FFFF);
      acc(1'b1, 1'b0, 32'h408, 32'h0, 4'h0, 32'h0);
      acc(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'h0);

      // Interrupts
      acc(1'b1, 1'b0, 32'h404, 32'h5, 4'hF, 32'h0);
      chk("irq_mask_only", {31'h0, user_irq}, 32'h0);
      s_irq = 4'b0001;
      @(posedge user_clk); #1;
      chk("irq_edge0", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h1);
      chk("irq_single", {31'h0, user_irq}, 32'h0);
      s_irq = 4'b0011;
      @(posedge user_clk); #1;
      chk("irq_masked_edge", {31'h0, user_irq}, 32'h0);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h3);
      acc(1'b1, 1'b0, 32'h400, 32'h2, 4'hF, 32'h0);
      chk("irq_w1c_left", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h1);
      s_irq = 4'b0111;
      @(posedge user_clk); #1;
      chk("irq_edge2", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h5);
      acc(1'b1, 1'b0, 32'h400, 32'h1, 4'hF, 32'h0);
      chk("irq_w1c_bit0", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h4);
      s_irq = 4'b0110;
      @(posedge user_clk); #1;
      s_irq = 4'b0111;
      acc(1'b1, 1'b0, 32'h400, 32'h1, 4'hF, 32'h0);
      chk("irq_edge_vs_w1c", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h5);
      acc(1'b1, 1'b0, 32'h404, 32'hFFFFFFF0, 4'h0, 32'h0);
      chk("irq_mask_wr_active", {31'h0, user_irq}, 32'h1);
      acc(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 32'h5);
      acc(1'b1, 1'b1, 32'h404, 32'hFFFFFFFA, 4'hF, 32'h5);
      chk("irq_mask_wr_idle", {31'h0, user_irq}, 32'h0);
      acc(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 32'hA);

      // Reset during a pending slave read
      acc(1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 32'h0);
      user_rden = 1'b1; user_addr = 32'h010;
      @(posedge user_clk); #1;
      user_rden = 1'b0; user_rst = 1'b1; s_irq = 4'b0000;
      @(posedge user_clk); #1;
      user_rst = 1'b0;
      chk("rst_rd_data", user_rd_data, 32'h0);
      chk("rst_irq", {31'h0, user_irq}, 32'h0);
      acc(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 32'h0);
      acc(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 32'h0);
      acc(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
